// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants for the stopwatch display path.
//   SEG_*      : 7-segment patterns {g,f,e,d,c,b,a}, active-low.
//   IDX_*      : scan-slot index of each BCD digit (0 = rightmost).
//   DP_MASK    : slots whose decimal point is lit as a separator.
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] IDX_CENT_0 = 3'd0;
    localparam logic [2:0] IDX_CENT_1 = 3'd1;
    localparam logic [2:0] IDX_SEC_0  = 3'd2;
    localparam logic [2:0] IDX_SEC_1  = 3'd3;
    localparam logic [2:0] IDX_MIN_0  = 3'd4;
    localparam logic [2:0] IDX_MIN_1  = 3'd5;
    localparam logic [2:0] IDX_HR_0   = 3'd6;
    localparam logic [2:0] IDX_HR_1   = 3'd7;

    // Separators sit after sec_0, min_0 and hr_0.
    localparam logic [7:0] DP_MASK = 8'b0101_0100;

endpackage

// File: rtl/stopwatch_display_mux_bcd_to_7seg.sv
// bcd_to_7seg
// Purely combinational BCD to 7-segment decoder.
//   bcd : 4-bit input code
//   seg : {g,f,e,d,c,b,a}, active-low; codes 10..15 show a dash
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// stopwatch_display_mux
// Scans eight BCD digits onto a common-anode 8-digit 7-segment display.
// The digits are captured once per frame so a frame never mixes two counts.
//   clk, rst         : clock, synchronous active-high reset
//   blank_lz         : enable hour leading-zero blanking (captured per frame)
//   i_hr_1..i_cent_0 : BCD digits, i_hr_1 most significant
//   an               : anode enables, active-low, an[7] = hr_1
//   seg, dp          : segments {g..a} and decimal point, active-low
//   frame_tick       : one-cycle pulse on each snapshot load
module stopwatch_display_mux
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blank_lz,
    input  logic [3:0] i_hr_1,
    input  logic [3:0] i_hr_0,
    input  logic [3:0] i_min_1,
    input  logic [3:0] i_min_0,
    input  logic [3:0] i_sec_1,
    input  logic [3:0] i_sec_0,
    input  logic [3:0] i_cent_1,
    input  logic [3:0] i_cent_0,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int             CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0][3:0]   snap_q, snap_d;
    logic              blank_q, blank_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_tick_q, frame_tick_d;

    logic [7:0][3:0]   in_digits;
    logic              load;
    logic              in_dead;
    logic [3:0]        cur_digit;
    logic [6:0]        dec_seg;

    assign in_digits = {i_hr_1, i_hr_0, i_min_1, i_min_0,
                        i_sec_1, i_sec_0, i_cent_1, i_cent_0};

    // With no dead time the comparison would be constant, so drop it entirely.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt_q < CW'(DEAD));
        end
    endgenerate

    // Prescaler, scan index and snapshot. On the load edge the freshly
    // captured digits are used for the output too, so slot 0 never shows
    // a digit from the previous frame even with dead time disabled.
    always_comb begin
        load    = (idx_q == 3'd0) && (cnt_q == '0);
        snap_d  = load ? in_digits : snap_q;
        blank_d = load ? blank_lz  : blank_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end
        cur_digit    = snap_d[idx_q];
        frame_tick_d = load;
    end

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Output selection. Blanking only ever replaces a real zero, so an
    // invalid hour code still shows its dash.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!in_dead) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = dec_seg;
            dp_d  = ~DP_MASK[idx_q];
            if (blank_d && (snap_d[IDX_HR_1] == 4'd0)) begin
                if (idx_q == IDX_HR_1) begin
                    seg_d = SEG_BLANK;
                end else if ((idx_q == IDX_HR_0) && (snap_d[IDX_HR_0] == 4'd0)) begin
                    seg_d = SEG_BLANK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_q       <= '0;
            blank_q      <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            blank_q      <= blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// tb_stopwatch_display_mux
// Bench for stopwatch_display_mux. Instance A uses CLK_DIV=4, DEAD=1 and is
// checked cycle by cycle against a reference model through an expectation
// queue, plus per-slot hand-written segment tables. Instance B uses DEAD=0
// and must always have exactly one anode low outside reset.
module tb_stopwatch_display_mux;

    localparam int CLK_DIV = 4;
    localparam int DEAD_A  = 1;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            blank_lz = 1'b0;
    logic [7:0][3:0] digits = '0;

    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, ft_a, ft_b;

    exp_t expq[$];
    int   tests = 0;
    int   failures = 0;

    int              m_cnt = 0;
    int              m_idx = 0;
    logic [7:0][3:0] m_snap = '0;
    logic            m_blank = 1'b0;
    logic            m_rst_last = 1'b1;

    logic       dir_en = 1'b0;
    logic [6:0] dir_seg [8];
    logic       dir_dp [8];

    stopwatch_display_mux #(.CLK_DIV(CLK_DIV), .DEAD(DEAD_A)) dut_a (
        .clk(clk), .rst(rst), .blank_lz(blank_lz),
        .i_hr_1(digits[7]), .i_hr_0(digits[6]),
        .i_min_1(digits[5]), .i_min_0(digits[4]),
        .i_sec_1(digits[3]), .i_sec_0(digits[2]),
        .i_cent_1(digits[1]), .i_cent_0(digits[0]),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(ft_a)
    );

    stopwatch_display_mux #(.CLK_DIV(CLK_DIV), .DEAD(0)) dut_b (
        .clk(clk), .rst(rst), .blank_lz(blank_lz),
        .i_hr_1(digits[7]), .i_hr_0(digits[6]),
        .i_min_1(digits[5]), .i_min_0(digits[4]),
        .i_sec_1(digits[3]), .i_sec_0(digits[2]),
        .i_cent_1(digits[1]), .i_cent_0(digits[0]),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(ft_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: on every edge, predict what the registered outputs
    // of instance A will hold after that edge and queue it.
    always @(posedge clk) begin : model
        exp_t            e;
        logic [7:0][3:0] s;
        logic            bl;
        m_rst_last <= rst;
        if (rst) begin
            e = {8'hFF, 7'h7F, 1'b1, 1'b0};
            m_cnt   <= 0;
            m_idx   <= 0;
            m_snap  <= '0;
            m_blank <= 1'b0;
        end else begin
            s  = m_snap;
            bl = m_blank;
            e.ft = (m_idx == 0 && m_cnt == 0);
            if (e.ft) begin
                s  = digits;
                bl = blank_lz;
            end
            m_snap  <= s;
            m_blank <= bl;
            if (m_cnt < DEAD_A) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.an  = ~(8'b1 << m_idx);
                e.seg = ref_seg(s[m_idx]);
                e.dp  = !(m_idx == 2 || m_idx == 4 || m_idx == 6);
                if (bl && m_idx == 7 && s[7] == 4'd0) e.seg = 7'h7F;
                if (bl && m_idx == 6 && s[7] == 4'd0 && s[6] == 4'd0) e.seg = 7'h7F;
            end
            if (m_cnt == CLK_DIV - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx + 1) % 8;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
        expq.push_back(e);
    end

    // Monitor: all comparisons happen here, half a cycle after each edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        int   slot;
        if (expq.size() != 0) begin
            e   = expq.pop_front();
            got = {an_a, seg_a, dp_a, ft_a};
            tests++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL model_cmp t=%0t got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         $time, got.an, got.seg, got.dp, got.ft, e.an, e.seg, e.dp, e.ft);
            end
        end
        if (!m_rst_last) begin
            tests++;
            if (an_b === 8'hFF || $countones(~an_b) != 1) begin
                failures++;
                $display("[TB] FAIL nodead_onehot t=%0t got an=%h want exactly one low bit", $time, an_b);
            end
        end
        if (dir_en && an_a !== 8'hFF) begin
            slot = -1;
            for (int i = 0; i < 8; i++) begin
                if (an_a[i] === 1'b0) slot = i;
            end
            if (slot >= 0) begin
                tests++;
                if (seg_a !== dir_seg[slot] || dp_a !== dir_dp[slot]) begin
                    failures++;
                    $display("[TB] FAIL slot%0d t=%0t got seg=%h dp=%b want seg=%h dp=%b",
                             slot, $time, seg_a, dp_a, dir_seg[slot], dir_dp[slot]);
                end
            end
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] dv, input logic bl);
        digits   = dv;
        blank_lz = bl;
    endtask

    // Wait (bounded) until the bench model reaches a given scan position.
    task automatic wait_state(input int idx, input int cnt);
        for (int k = 0; k < 64; k++) begin
            if (m_idx == idx && m_cnt == cnt) break;
            run_cycles(1);
        end
    endtask

    // Hold inputs steady, let two frames pass, then check one frame against
    // a hand-written table (segs packed slot7..slot0, dps bit i = slot i).
    task automatic check_steady(input logic [31:0] dv, input logic bl,
                                input logic [55:0] segs, input logic [7:0] dps);
        dir_en = 1'b0;
        apply_stimulus(dv, bl);
        run_cycles(64);
        for (int i = 0; i < 8; i++) begin
            dir_seg[i] = segs[i*7 +: 7];
            dir_dp[i]  = dps[i];
        end
        dir_en = 1'b1;
        run_cycles(32);
        dir_en = 1'b0;
    endtask

    localparam logic [7:0] DPS = 8'b1010_1011;

    initial begin
        for (int i = 0; i < 8; i++) begin
            dir_seg[i] = 7'h7F;
            dir_dp[i]  = 1'b1;
        end

        // Reset and bring-up
        apply_stimulus(32'h0000_0000, 1'b0);
        run_cycles(2);
        rst = 1'b0;
        run_cycles(40);

        // Digit mapping
        check_steady(32'h1234_5678, 1'b0,
                     {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, DPS);

        // Tear-free snapshot: change mid slot 3
        wait_state(3, 2);
        apply_stimulus(32'h9999_9999, 1'b0);
        run_cycles(64);
        check_steady(32'h9999_9999, 1'b0,
                     {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}, DPS);

        // Leading-zero blanking
        check_steady(32'h0034_5678, 1'b1,
                     {7'h7F, 7'h7F, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, DPS);
        check_steady(32'h0534_5678, 1'b1,
                     {7'h7F, 7'h12, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, DPS);
        check_steady(32'h0034_5678, 1'b0,
                     {7'h40, 7'h40, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, DPS);

        // Invalid BCD on sec_0
        check_steady(32'h1234_5C78, 1'b0,
                     {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h3F, 7'h78, 7'h00}, DPS);

        // Reset mid-slot at idx 5, cnt 2, then restart with new digits
        wait_state(5, 2);
        rst = 1'b1;
        apply_stimulus(32'h8765_4321, 1'b0);
        run_cycles(1);
        rst = 1'b0;
        run_cycles(40);

        run_cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
